// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bus of the immediate generator: instruction in, decoded immediate out.
// The slave side is the generator; the master side is whoever feeds and drains it.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [7:0]      err_cnt;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, err_cnt
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, err_cnt
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator behind a single-entry valid/ready stage.
// EN_RV64=1 is only meaningful together with XLEN=64.
module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter bit EN_RV64 = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    imm_gen_pipe_if.slave bus
);
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ZIMM  = 3'd7
    } fmt_e;

    logic [31:0]     instr_s;
    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [31:0]     imm32_s;
    logic [XLEN-1:0] imm_s;
    fmt_e            fmt_s;
    logic            illegal_s;
    logic            in_ready_s;
    logic            accept_s;

    logic            valid_q,   valid_d;
    logic [XLEN-1:0] imm_q,     imm_d;
    fmt_e            fmt_q,     fmt_d;
    logic            illegal_q, illegal_d;
    logic [7:0]      err_q,     err_d;

    assign instr_s  = bus.in_instr;
    assign opcode_s = instr_s[6:0];
    assign funct3_s = instr_s[14:12];

    // Opcode decode to a 32-bit immediate; shamt/zimm keep bit 31 clear so one sign extension serves all formats.
    always_comb begin
        imm32_s   = 32'd0;
        fmt_s     = FMT_NONE;
        illegal_s = 1'b0;
        case (opcode_s)
            OPC_OP_IMM: begin
                if (funct3_s == 3'b001 || funct3_s == 3'b101) begin
                    fmt_s   = FMT_SHAMT;
                    imm32_s = EN_RV64 ? {26'd0, instr_s[25:20]} : {27'd0, instr_s[24:20]};
                end else begin
                    fmt_s   = FMT_I;
                    imm32_s = {{20{instr_s[31]}}, instr_s[31:20]};
                end
            end
            OPC_OP_IMM32: begin
                if (!EN_RV64) begin
                    illegal_s = 1'b1;
                end else if (funct3_s == 3'b001 || funct3_s == 3'b101) begin
                    fmt_s   = FMT_SHAMT;
                    imm32_s = {27'd0, instr_s[24:20]};
                end else begin
                    fmt_s   = FMT_I;
                    imm32_s = {{20{instr_s[31]}}, instr_s[31:20]};
                end
            end
            OPC_LOAD, OPC_JALR: begin
                fmt_s   = FMT_I;
                imm32_s = {{20{instr_s[31]}}, instr_s[31:20]};
            end
            OPC_STORE: begin
                fmt_s   = FMT_S;
                imm32_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
            end
            OPC_BRANCH: begin
                fmt_s   = FMT_B;
                imm32_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25],
                           instr_s[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_s   = FMT_U;
                imm32_s = {instr_s[31:12], 12'd0};
            end
            OPC_JAL: begin
                fmt_s   = FMT_J;
                imm32_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20],
                           instr_s[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
                if (funct3_s[2]) begin
                    fmt_s   = FMT_ZIMM;
                    imm32_s = {27'd0, instr_s[19:15]};
                end else begin
                    fmt_s   = FMT_NONE;
                end
            end
            OPC_OP: begin
                fmt_s = FMT_NONE;
            end
            OPC_OP32: begin
                illegal_s = ~EN_RV64;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
        imm_s = XLEN'(signed'(imm32_s));
    end

    assign in_ready_s = ~valid_q | bus.out_ready;
    assign accept_s   = bus.in_valid & in_ready_s;

    // Next state of the output stage: load on accept, drop after transfer, otherwise hold.
    always_comb begin
        valid_d   = valid_q;
        imm_d     = imm_q;
        fmt_d     = fmt_q;
        illegal_d = illegal_q;
        err_d     = err_q;
        if (accept_s) begin
            valid_d   = 1'b1;
            imm_d     = imm_s;
            fmt_d     = fmt_s;
            illegal_d = illegal_s;
            if (illegal_s && err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end else begin
                err_d = err_q;
            end
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            imm_q     <= '0;
            fmt_q     <= FMT_NONE;
            illegal_q <= 1'b0;
            err_q     <= 8'd0;
        end else begin
            valid_q   <= valid_d;
            imm_q     <= imm_d;
            fmt_q     <= fmt_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = valid_q;
    assign bus.out_imm     = imm_q;
    assign bus.out_fmt     = fmt_q;
    assign bus.out_illegal = illegal_q;
    assign bus.err_cnt     = err_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives an RV32 and an RV64 generator with the same stimulus and checks both
// against an arithmetic decode model and a queue of accepted words.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) if32 ();
    imm_gen_pipe_if #(.XLEN(64)) if64 ();

    assign if32.in_valid  = in_valid;
    assign if32.in_instr  = in_instr;
    assign if32.out_ready = out_ready;
    assign if64.in_valid  = in_valid;
    assign if64.in_instr  = in_instr;
    assign if64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .EN_RV64(1'b0)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    imm_gen_pipe #(.XLEN(64), .EN_RV64(1'b1)) u64 (.clk(clk), .rst_n(rst_n), .bus(if64));

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } dec_t;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Decode from the ISA field layout using signed integer arithmetic.
    function automatic dec_t model(input logic [31:0] w, input bit rv64);
        dec_t   d;
        int     s;
        int     t;
        longint l;
        logic [2:0] f3;
        s = w;
        t = 0;
        f3 = w[14:12];
        d.fmt = 3'd0;
        d.ill = 1'b0;
        case (w[6:0])
            7'b0010011, 7'b0011011: begin
                if (w[6:0] == 7'b0011011 && !rv64) d.ill = 1'b1;
                else if (f3 == 3'b001 || f3 == 3'b101) begin
                    d.fmt = 3'd6;
                    t = (w[6:0] == 7'b0010011 && rv64) ? int'(w[25:20]) : int'(w[24:20]);
                end else begin
                    d.fmt = 3'd1;
                    t = s >>> 20;
                end
            end
            7'b0000011, 7'b1100111: begin d.fmt = 3'd1; t = s >>> 20; end
            7'b0100011: begin d.fmt = 3'd2; t = (s >>> 25) * 32 + int'(w[11:7]); end
            7'b1100011: begin
                d.fmt = 3'd3;
                t = (s >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            end
            7'b0110111, 7'b0010111: begin d.fmt = 3'd4; t = (s >>> 12) * 4096; end
            7'b1101111: begin
                d.fmt = 3'd5;
                t = (s >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            end
            7'b1110011: if (f3[2]) begin d.fmt = 3'd7; t = int'(w[19:15]); end
            7'b0110011: d.ill = 1'b0;
            7'b0111011: d.ill = !rv64;
            default:    d.ill = 1'b1;
        endcase
        l = t;
        d.imm = l;
        return d;
    endfunction

    logic [31:0] q[$];
    int ill32 = 0;
    int ill64 = 0;

    // Scoreboard: words accepted at each edge, retired when the consumer takes them.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            ill32 = 0;
            ill64 = 0;
        end else begin
            bit rdy;
            rdy = (q.size() == 0) || out_ready;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && rdy) begin
                q.push_back(in_instr);
                if (model(in_instr, 1'b0).ill && ill32 < 255) ill32++;
                if (model(in_instr, 1'b1).ill && ill64 < 255) ill64++;
            end
        end
    end

    dec_t e32, e64;
    bit   ev, er;

    // Per-cycle comparison of both DUTs against the scoreboard.
    initial forever begin
        @(negedge clk);
        ev = (q.size() != 0);
        er = !ev || out_ready;
        chk("in_ready32",  64'(if32.in_ready),  64'(er));
        chk("in_ready64",  64'(if64.in_ready),  64'(er));
        chk("out_valid32", 64'(if32.out_valid), 64'(ev));
        chk("out_valid64", 64'(if64.out_valid), 64'(ev));
        chk("err_cnt32",   64'(if32.err_cnt),   64'(ill32));
        chk("err_cnt64",   64'(if64.err_cnt),   64'(ill64));
        if (ev) begin
            e32 = model(q[0], 1'b0);
            e64 = model(q[0], 1'b1);
            chk("imm32", 64'(if32.out_imm), {32'd0, e32.imm[31:0]});
            chk("fmt32", 64'(if32.out_fmt), 64'(e32.fmt));
            chk("ill32", 64'(if32.out_illegal), 64'(e32.ill));
            chk("imm64", if64.out_imm, e64.imm);
            chk("fmt64", 64'(if64.out_fmt), 64'(e64.fmt));
            chk("ill64", 64'(if64.out_illegal), 64'(e64.ill));
        end
    end

    // Presents one word for one cycle; called away from the rising edge.
    task automatic send(input logic [31:0] w);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_instr = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_instr = 32'hDEADBEEF;
    endtask

    logic [31:0] stream [8] = '{32'hFE112E23, 32'h00C12083, 32'h00001017, 32'h34011073,
                                32'h002081B3, 32'h02209093, 32'h4010D09B, 32'h00008067};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",  64'(if32.out_valid), 64'd0);
        chk("rst_imm64",  if64.out_imm, 64'd0);
        chk("rst_fmt",    64'(if32.out_fmt), 64'd0);
        chk("rst_ill",    64'(if64.out_illegal), 64'd0);
        chk("rst_err",    64'(if32.err_cnt), 64'd0);
        rst_n = 1'b1;

        send(32'hFFF00093); @(negedge clk);
        chk("addi_valid", 64'(if32.out_valid), 64'd1);
        chk("addi_fmt",   64'(if32.out_fmt), 64'd1);
        chk("addi_imm32", 64'(if32.out_imm), 64'hFFFFFFFF);
        chk("addi_imm64", if64.out_imm, 64'hFFFFFFFFFFFFFFFF);
        chk("addi_ill",   64'(if32.out_illegal), 64'd0);
        send(32'h43F0D093); @(negedge clk);
        chk("srai_fmt",   64'(if64.out_fmt), 64'd6);
        chk("srai_imm64", if64.out_imm, 64'h000000000000003F);
        chk("srai_imm32", 64'(if32.out_imm), 64'h1F);
        send(32'h800000B7); @(negedge clk);
        chk("lui_imm64",  if64.out_imm, 64'hFFFFFFFF80000000);
        chk("lui_imm32",  64'(if32.out_imm), 64'h80000000);
        send(32'hFE000EE3); @(negedge clk);
        chk("br_fmt",     64'(if32.out_fmt), 64'd3);
        chk("br_imm",     64'(if32.out_imm), 64'hFFFFFFFC);
        send(32'h0040006F); @(negedge clk);
        chk("jal_fmt",    64'(if32.out_fmt), 64'd5);
        chk("jal_imm",    64'(if32.out_imm), 64'd4);
        send(32'h000FD073); @(negedge clk);
        chk("zimm_fmt",   64'(if32.out_fmt), 64'd7);
        chk("zimm_imm",   64'(if32.out_imm), 64'd31);
        send(32'h0000007F); @(negedge clk);
        chk("bad_ill",    64'(if32.out_illegal), 64'd1);
        chk("bad_err32",  64'(if32.err_cnt), 64'd1);
        chk("bad_err64",  64'(if64.err_cnt), 64'd1);
        send(32'hFFF0809B); @(negedge clk);
        chk("addiw_ill32", 64'(if32.out_illegal), 64'd1);
        chk("addiw_ill64", 64'(if64.out_illegal), 64'd0);
        chk("addiw_imm64", if64.out_imm, 64'hFFFFFFFFFFFFFFFF);
        chk("addiw_err32", 64'(if32.err_cnt), 64'd2);
        send(32'h0000003B); @(negedge clk);
        chk("addw_err32", 64'(if32.err_cnt), 64'd3);
        chk("addw_err64", 64'(if64.err_cnt), 64'd1);

        // Back-to-back stream at full throughput.
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_instr = stream[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("sw_after_stream_valid", 64'(if32.out_valid), 64'd1);

        // Back-pressure: A held for three cycles while B waits on the input.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093;
        @(posedge clk); #1;
        in_instr = 32'h0040006F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(if32.in_ready), 64'd0);
            chk("bp_hold_imm", 64'(if32.out_imm), 64'hFFFFFFFF);
            chk("bp_hold_fmt", 64'(if32.out_fmt), 64'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_fmt", 64'(if32.out_fmt), 64'd5);
        chk("bp_second_imm", 64'(if32.out_imm), 64'd4);
        chk("bp_second_vld", 64'(if32.out_valid), 64'd1);
        @(negedge clk);
        chk("bp_drained", 64'(if32.out_valid), 64'd0);

        // Saturation of the illegal-word counter.
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = 32'h0000007F;
        repeat (300) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("sat_err32", 64'(if32.err_cnt), 64'd255);
        chk("sat_err64", 64'(if64.err_cnt), 64'd255);

        // Reset while a word is held under back-pressure.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00C12083;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_pre", 64'(if64.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid32", 64'(if32.out_valid), 64'd0);
        chk("rst_mid_valid64", 64'(if64.out_valid), 64'd0);
        chk("rst_mid_err",     64'(if32.err_cnt), 64'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(if32.in_ready), 64'd1);
        chk("rel_no_word",  64'(if64.out_valid), 64'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
